// File: rtl/instruction_encoder_if.sv
// Handshake bundle for instruction_encoder: assembler-field input channel
// and encoded-word output channel. The encoder uses the slave modport; the
// loader (or bench) driving fields and consuming words uses master.
interface instruction_encoder_if #(
  parameter int ADDR_W = 8
);
  // Input channel: one assembler-level instruction per handshake
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        opcode_in;
  logic [2:0]        rd;
  logic [2:0]        rs1;
  logic [2:0]        rs2;
  logic [6:0]        immediate;
  logic [5:0]        nzimm;
  logic [8:0]        offset;

  // Output channel: encoded word plus its instruction-memory address
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_word;
  logic [ADDR_W-1:0] out_addr;

  modport slave (
    input  in_valid, opcode_in, rd, rs1, rs2, immediate, nzimm, offset,
    input  out_ready,
    output in_ready,
    output out_valid, out_word, out_addr
  );

  modport master (
    output in_valid, opcode_in, rd, rs1, rs2, immediate, nzimm, offset,
    output out_ready,
    input  in_ready,
    input  out_valid, out_word, out_addr
  );
endinterface

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs assembler fields into 16-bit instruction words
// and streams them with consecutive write addresses, `count` legal words per
// `start`. Illegal inputs are dropped and counted.
// Optional build macro: ENC_RANGE_CHECK_EN -- also rejects N6 instructions
// with a zero immediate and shifts whose amount exceeds 15.
module instruction_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  instruction_encoder_if.slave bus,
  output logic              err_illegal,
  output logic [7:0]        err_count,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] remaining_q;
  logic              out_valid_q;
  logic [15:0]       out_word_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              in_ready;
  logic              accept;
  logic              legal;
  logic [15:0]       enc_word;

  assign accept        = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = out_word_q;
  assign bus.out_addr  = out_addr_q;

  // Legality of the presented opcode (plus optional immediate range checks)
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    legal = (bus.opcode_in[3:2] != 2'b11);
`ifdef ENC_RANGE_CHECK_EN
    if ((bus.opcode_in == 4'h3 || bus.opcode_in == 4'h8 || bus.opcode_in == 4'h9)
        && bus.nzimm == 6'd0)
      legal = 1'b0;
    if ((bus.opcode_in == 4'h8 || bus.opcode_in == 4'h9) && bus.nzimm[5:4] != 2'b00)
      legal = 1'b0;
`endif
  end

  // Field packing by instruction format
  always_comb begin
    enc_word        = '0;
    enc_word[15:12] = bus.opcode_in;
    case (bus.opcode_in)
      4'h2, 4'h4, 4'h6, 4'h7: enc_word[11:0] = {bus.rd, bus.rs1, bus.rs2, 3'b000};
      4'h3, 4'h8, 4'h9:       enc_word[11:0] = {bus.rd, bus.rs1, bus.nzimm};
      4'h0, 4'h1, 4'h5:       enc_word[11:0] = {bus.rd, bus.immediate, 2'b00};
      4'hA, 4'hB:             enc_word[11:0] = {bus.rs1, bus.offset};
      default:                enc_word[11:0] = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (count == '0) ? DRAIN : LOAD;
      LOAD:    if (accept && legal && remaining_q == ADDR_W'(1)) state_d = DRAIN;
      DRAIN:   if (!out_valid_q || bus.out_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the state register
  always_comb begin
    in_ready = (state_q == LOAD) && (!out_valid_q || bus.out_ready);
    busy     = (state_q == LOAD) || (state_q == DRAIN);
    done     = (state_q == DONE);
  end

  // Burst bookkeeping, single-entry output register and error reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_addr_q  <= '0;
      err_illegal <= 1'b0;
      err_count   <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        addr_q      <= base_addr;
        remaining_q <= count;
      end

      if (accept && legal) begin
        out_valid_q <= 1'b1;
        out_word_q  <= enc_word;
        out_addr_q  <= addr_q;
        addr_q      <= addr_q + ADDR_W'(1);
        remaining_q <= remaining_q - ADDR_W'(1);
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      err_illegal <= accept && !legal;
      if (accept && !legal && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

endmodule
